// File: rtl/guess_checker_if.sv
// Guess handshake and result channel between the player front end and guess_checker.
interface guess_checker_if;
  logic       guess_valid;
  logic [4:0] guess_letter;
  logic       guess_ready;
  logic       result_valid;
  logic [1:0] result_code;

  modport master (
    output guess_valid, guess_letter,
    input  guess_ready, result_valid, result_code
  );

  modport slave (
    input  guess_valid, guess_letter,
    output guess_ready, result_valid, result_code
  );
endinterface

// File: rtl/guess_checker.sv
// Scores letter guesses against the latched secret word and raises win/lost for the game FSM.
// state    | meaning
// S_IDLE   | waiting for a guess while the game is INGAME
// S_SCAN   | comparing one word position per cycle against the latched guess
// S_RESULT | publishing result_valid/code, counters and win/lost flags
module guess_checker #(
  parameter int WORD_LEN  = 8,
  parameter int MAX_WRONG = 6,
  parameter int IDX_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            i_game_state,
  input  logic                  i_word_load,
  input  logic [5*WORD_LEN-1:0] i_word_in,
  input  logic [IDX_W:0]        i_word_length,
  guess_checker_if.slave        g_if,
  output logic [WORD_LEN-1:0]   o_revealed_mask,
  output logic [25:0]           o_used_letters,
  output logic [3:0]            o_wrong_count,
  output logic                  o_win_game,
  output logic                  o_lost_game
);

  localparam int LEN_W = IDX_W + 1;
  localparam logic [1:0] GS_START  = 2'd0;
  localparam logic [1:0] GS_INGAME = 2'd1;
  localparam logic [1:0] RC_HIT     = 2'b00;
  localparam logic [1:0] RC_MISS    = 2'b01;
  localparam logic [1:0] RC_REPEAT  = 2'b10;
  localparam logic [1:0] RC_INVALID = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESULT} state_t;

  state_t                r_state;
  logic [5*WORD_LEN-1:0] r_word;
  logic [LEN_W-1:0]      r_len;
  logic [IDX_W-1:0]      r_idx;
  logic [4:0]            r_guess;
  logic [1:0]            r_code;
  logic [WORD_LEN-1:0]   r_mask;
  logic [25:0]           r_used;
  logic [3:0]            r_wrong;
  logic                  r_win;
  logic                  r_lost;
  logic                  r_result_valid;
  logic [1:0]            r_result_code;

  logic                w_ingame;
  logic                w_accept;
  logic                w_invalid;
  logic                w_repeat;
  logic [31:0]         w_used32;
  logic [4:0]          w_cur_letter;
  logic                w_last;
  logic [3:0]          w_wrong_next;
  logic [WORD_LEN-1:0] w_pos_used;
  logic                w_win;
  logic                w_lost;
  logic [LEN_W-1:0]    w_len_clamped;
  logic [25:0]         w_guess_onehot;

  assign w_ingame         = (i_game_state == GS_INGAME);
  assign g_if.guess_ready = (r_state == S_IDLE) & w_ingame & ~r_win & ~r_lost;
  assign w_accept         = g_if.guess_valid & g_if.guess_ready;
  assign w_invalid        = (g_if.guess_letter > 5'd25);
  assign w_used32         = {6'b0, r_used};
  assign w_repeat         = w_used32[g_if.guess_letter];
  assign w_cur_letter     = r_word[5*int'(r_idx) +: 5];
  // second term bounds the scan even if no word was ever loaded (r_len still 0)
  assign w_last           = ({1'b0, r_idx} == r_len - 1'b1) |
                            (r_idx == IDX_W'(WORD_LEN - 1));
  assign w_wrong_next     = (r_code == RC_MISS) ? r_wrong + 4'd1 : r_wrong;
  assign w_win            = &(r_mask | ~w_pos_used);
  assign w_lost           = (w_wrong_next == 4'(MAX_WRONG));
  assign w_guess_onehot   = 26'(32'd1 << r_guess);

  // positions beyond the word length count as already revealed
  always_comb begin
    w_pos_used = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      w_pos_used[i] = (i < int'(r_len));
    end
  end

  always_comb begin
    w_len_clamped = i_word_length;
    if ((i_word_length == '0) || (int'(i_word_length) > WORD_LEN)) begin
      w_len_clamped = LEN_W'(WORD_LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_word         <= '0;
      r_len          <= '0;
      r_idx          <= '0;
      r_guess        <= '0;
      r_code         <= RC_HIT;
      r_mask         <= '0;
      r_used         <= '0;
      r_wrong        <= '0;
      r_win          <= 1'b0;
      r_lost         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_code  <= RC_HIT;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_guess <= g_if.guess_letter;
            r_idx   <= '0;
            if (w_invalid) begin
              r_code  <= RC_INVALID;
              r_state <= S_RESULT;
            end else if (w_repeat) begin
              r_code  <= RC_REPEAT;
              r_state <= S_RESULT;
            end else begin
              r_code  <= RC_MISS;
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (!w_ingame) begin
            r_state <= S_IDLE;
          end else begin
            if (w_cur_letter == r_guess) begin
              r_mask[r_idx] <= 1'b1;
              r_code        <= RC_HIT;
            end
            if (w_last) begin
              r_state <= S_RESULT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_RESULT: begin
          r_state <= S_IDLE;
          if (w_ingame) begin
            r_result_valid <= 1'b1;
            r_result_code  <= r_code;
            r_wrong        <= w_wrong_next;
            r_win          <= w_win;
            r_lost         <= w_lost;
            if (r_code != RC_INVALID) begin
              r_used <= r_used | w_guess_onehot;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (i_game_state == GS_START) begin
        r_win  <= 1'b0;
        r_lost <= 1'b0;
        if (i_word_load) begin
          r_word  <= i_word_in;
          r_len   <= w_len_clamped;
          r_mask  <= '0;
          r_used  <= '0;
          r_wrong <= '0;
        end
      end
    end
  end

  assign g_if.result_valid = r_result_valid;
  assign g_if.result_code  = r_result_code;
  assign o_revealed_mask   = r_mask;
  assign o_used_letters    = r_used;
  assign o_wrong_count     = r_wrong;
  assign o_win_game        = r_win;
  assign o_lost_game       = r_lost;

endmodule

// File: tb/tb_guess_checker.sv
// Scoreboard bench for guess_checker: a behavioural game model predicts each result and its arrival cycle.
module tb_guess_checker;
  localparam int WL = 8;
  localparam int MW = 6;
  localparam logic [1:0] GS_START  = 2'd0;
  localparam logic [1:0] GS_INGAME = 2'd1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    game_state;
  logic          word_load;
  logic [5*WL-1:0] word_in;
  logic [3:0]    word_length;
  logic [WL-1:0] mask;
  logic [25:0]   used;
  logic [3:0]    wrong;
  logic          win;
  logic          lost;

  always #5 clk = ~clk;

  guess_checker_if gif ();

  guess_checker #(.WORD_LEN(WL), .MAX_WRONG(MW), .IDX_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_game_state   (game_state),
    .i_word_load    (word_load),
    .i_word_in      (word_in),
    .i_word_length  (word_length),
    .g_if           (gif),
    .o_revealed_mask(mask),
    .o_used_letters (used),
    .o_wrong_count  (wrong),
    .o_win_game     (win),
    .o_lost_game    (lost)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]    code;
    logic [WL-1:0] mask;
    logic [25:0]   used;
    logic [3:0]    wrong;
    logic          win;
    logic          lost;
    int            due;
  } exp_t;
  exp_t sb[$];

  // reference game model
  logic [4:0]    m_word[WL];
  int            m_len;
  logic [WL-1:0] m_mask;
  logic [25:0]   m_used;
  int            m_wrong;

  always @(negedge clk) begin
    if (gif.result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(gif.result_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("code",    32'(gif.result_code), 32'(e.code));
        check("mask",    32'(mask),  32'(e.mask));
        check("used",    32'(used),  32'(e.used));
        check("wrong",   32'(wrong), 32'(e.wrong));
        check("win",     32'(win),   32'(e.win));
        check("lost",    32'(lost),  32'(e.lost));
        check("latency", 32'(cyc),   32'(e.due));
      end
    end
  end

  task automatic load_word(input logic [5*WL-1:0] w, input int len);
    @(negedge clk);
    game_state  = GS_START;
    word_in     = w;
    word_length = 4'(len);
    word_load   = 1'b1;
    @(negedge clk);
    word_load   = 1'b0;
    m_len   = (len == 0 || len > WL) ? WL : len;
    for (int i = 0; i < WL; i++) m_word[i] = w[5*i +: 5];
    m_mask  = '0;
    m_used  = '0;
    m_wrong = 0;
  endtask

  task automatic accept_guess(input logic [4:0] letter, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!gif.guess_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) check("ready_timeout", 32'(gif.guess_ready), 32'd1);
    gif.guess_valid  = 1'b1;
    gif.guess_letter = letter;
    @(posedge clk);
    #1;
    t = cyc;
    gif.guess_valid = 1'b0;
  endtask

  task automatic expect_guess(input logic [4:0] letter);
    exp_t e;
    int   t;
    int   k;
    bit   hit;
    if (letter > 5'd25) begin
      e.code = 2'b11;
    end else if (m_used[int'(letter)]) begin
      e.code = 2'b10;
    end else begin
      hit = 1'b0;
      for (int i = 0; i < m_len; i++) begin
        if (m_word[i] == letter) begin
          hit = 1'b1;
          m_mask[i] = 1'b1;
        end
      end
      e.code = hit ? 2'b00 : 2'b01;
      if (!hit) m_wrong++;
      m_used[int'(letter)] = 1'b1;
    end
    e.mask  = m_mask;
    e.used  = m_used;
    e.wrong = 4'(m_wrong);
    e.win   = 1'b1;
    for (int i = 0; i < m_len; i++) if (!m_mask[i]) e.win = 1'b0;
    e.lost  = (m_wrong == MW);
    accept_guess(letter, t);
    e.due = t + ((e.code == 2'b00 || e.code == 2'b01) ? m_len + 1 : 1);
    sb.push_back(e);
    k = 0;
    while (sb.size() > 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      check("result_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5*WL-1:0] w_cab;
    logic [5*WL-1:0] w_abc;
    int   t;
    bit   seen;

    w_cab = {25'd0, 5'd1, 5'd0, 5'd2};
    w_abc = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

    reset = 1'b1;
    game_state = GS_START;
    word_load = 1'b0;
    word_in = '0;
    word_length = '0;
    gif.guess_valid = 1'b0;
    gif.guess_letter = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mask",  32'(mask),  32'd0);
    check("rst_used",  32'(used),  32'd0);
    check("rst_wrong", 32'(wrong), 32'd0);
    check("rst_win",   32'(win),   32'd0);
    check("rst_lost",  32'(lost),  32'd0);
    check("rst_rv",    32'(gif.result_valid), 32'd0);
    check("rst_ready_start", 32'(gif.guess_ready), 32'd0);

    // hit, miss, repeat on "CAB"
    load_word(w_cab, 3);
    game_state = GS_INGAME;
    @(negedge clk);
    check("ready_ingame", 32'(gif.guess_ready), 32'd1);
    expect_guess(5'd0);
    expect_guess(5'd25);
    expect_guess(5'd25);

    // win, then START clears the flag
    load_word(w_cab, 3);
    game_state = GS_INGAME;
    expect_guess(5'd2);
    expect_guess(5'd0);
    expect_guess(5'd1);
    @(negedge clk);
    check("win_ready", 32'(gif.guess_ready), 32'd0);
    game_state = GS_START;
    @(negedge clk);
    check("start_clears_win", 32'(win), 32'd0);

    // six misses lose; later guesses refused
    load_word(w_cab, 3);
    game_state = GS_INGAME;
    for (int i = 3; i < 9; i++) expect_guess(5'(i));
    check("lost_ready", 32'(gif.guess_ready), 32'd0);
    @(negedge clk);
    gif.guess_valid  = 1'b1;
    gif.guess_letter = 5'd9;
    repeat (6) @(negedge clk);
    gif.guess_valid = 1'b0;
    check("lost_wrong_hold", 32'(wrong), 32'(MW));
    check("lost_used_hold",  32'(used[9]), 32'd0);

    // invalid code, then a zero length load meaning the full word
    load_word(w_cab, 3);
    game_state = GS_INGAME;
    expect_guess(5'd30);
    load_word(w_abc, 0);
    game_state = GS_INGAME;
    expect_guess(5'd7);
    expect_guess(5'd3);

    // abort mid-scan keeps partial mask and produces no result
    load_word({WL{5'd0}}, 8);
    game_state = GS_INGAME;
    accept_guess(5'd0, t);
    @(posedge clk);
    @(posedge clk);
    #1;
    game_state = GS_START;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | gif.result_valid;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    check("abort_mask", 32'(mask), 32'h03);
    game_state = GS_INGAME;
    @(negedge clk);
    check("abort_idle_ready", 32'(gif.guess_ready), 32'd1);

    // reset while scanning
    accept_guess(5'd0, t);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_mask",  32'(mask),  32'd0);
    check("midrst_used",  32'(used),  32'd0);
    check("midrst_wrong", 32'(wrong), 32'd0);
    check("midrst_win",   32'(win),   32'd0);
    check("midrst_lost",  32'(lost),  32'd0);
    check("midrst_rv",    32'(gif.result_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | gif.result_valid;
    end
    check("midrst_no_result", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
